// File: rtl/vr_filter.sv
// VR input conditioning: synchroniser, glitch filter and adaptive blanking
// ahead of hwag.cap; also reports the measured tooth period.
module vr_filter #(
    parameter int WIDTH       = 24,
    parameter int FILT_LEN    = 4,
    parameter int BLANK_SHIFT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vr_in,
    input  logic             blank_en,
    output logic             cap,
    output logic             cap_rise,
    output logic             rejected,
    output logic [WIDTH-1:0] period,
    output logic             period_valid,
    output logic             ovf
);

    typedef enum logic {
        ST_FIRST = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam logic [3:0] FILT_LAST = 4'(FILT_LEN - 1);

    state_t           state_q, state_d;
    logic             s1_q, s2_q;
    logic             f_q, f_d;
    logic [3:0]       fcnt_q, fcnt_d;
    logic [WIDTH-1:0] pcnt_q, pcnt_d;
    logic [WIDTH-1:0] bcnt_q, bcnt_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic [WIDTH-1:0] meas;
    logic             cap_q, cap_d;
    logic             cap_rise_q, cap_rise_d;
    logic             rej_q, rej_d;
    logic             pv_q, pv_d;
    logic             ovf_q, ovf_d;
    logic             f_rise, f_fall, accept;

    // f toggles once s2 has disagreed with it for FILT_LEN consecutive clocks.
    always_comb begin
        f_d    = f_q;
        fcnt_d = '0;
        if (s2_q != f_q) begin
            if (fcnt_q == FILT_LAST) begin
                f_d = ~f_q;
            end else begin
                fcnt_d = fcnt_q + 4'd1;
            end
        end
    end

    assign f_rise = f_d & ~f_q;
    assign f_fall = ~f_d & f_q;
    assign meas   = pcnt_q + WIDTH'(1);

    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        pcnt_d     = (&pcnt_q) ? pcnt_q : meas;
        bcnt_d     = (bcnt_q == '0) ? bcnt_q : bcnt_q - WIDTH'(1);
        period_d   = period_q;
        pv_d       = 1'b0;
        cap_rise_d = 1'b0;
        rej_d      = 1'b0;
        ovf_d      = ovf_q;
        cap_d      = f_fall ? 1'b0 : cap_q;
        case (state_q)
            ST_FIRST: begin
                if (f_rise) begin
                    accept  = 1'b1;
                    bcnt_d  = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // bcnt_q must already be zero; a rise on the edge it expires is still blanked.
                if (f_rise && (bcnt_q == '0 || !blank_en)) begin
                    accept   = 1'b1;
                    period_d = meas;
                    pv_d     = 1'b1;
                    bcnt_d   = blank_en ? (meas >> BLANK_SHIFT) : '0;
                end else begin
                    rej_d = f_rise;
                    if (&pcnt_d) begin
                        ovf_d   = 1'b1;
                        state_d = ST_FIRST;
                    end
                end
            end
            default: state_d = ST_FIRST;
        endcase
        if (accept) begin
            pcnt_d     = '0;
            cap_d      = 1'b1;
            cap_rise_d = 1'b1;
            ovf_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_FIRST;
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            f_q        <= 1'b0;
            fcnt_q     <= '0;
            pcnt_q     <= '0;
            bcnt_q     <= '0;
            period_q   <= '0;
            cap_q      <= 1'b0;
            cap_rise_q <= 1'b0;
            rej_q      <= 1'b0;
            pv_q       <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            s1_q       <= vr_in;
            s2_q       <= s1_q;
            f_q        <= f_d;
            fcnt_q     <= fcnt_d;
            pcnt_q     <= pcnt_d;
            bcnt_q     <= bcnt_d;
            period_q   <= period_d;
            cap_q      <= cap_d;
            cap_rise_q <= cap_rise_d;
            rej_q      <= rej_d;
            pv_q       <= pv_d;
            ovf_q      <= ovf_d;
        end
    end

    assign cap          = cap_q;
    assign cap_rise     = cap_rise_q;
    assign rejected     = rej_q;
    assign period       = period_q;
    assign period_valid = pv_q;
    assign ovf          = ovf_q;

endmodule

// File: tb/tb_vr_filter.sv
// Bench for vr_filter (WIDTH=8): event-level reference model compared every
// cycle, plus directed tooth patterns with hand-computed expectations.
module tb_vr_filter;

    localparam int W  = 8;
    localparam int FL = 4;
    localparam int BS = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         vr_in = 1'b0;
    logic         blank_en = 1'b1;
    logic         cap, cap_rise, rejected, period_valid, ovf;
    logic [W-1:0] period;

    int total = 0;
    int bad   = 0;
    int cnt_rise = 0, cnt_pv = 0, cnt_rej = 0, cnt_hi = 0;
    int b_rise, b_pv, b_rej, b_hi;

    vr_filter #(.WIDTH(W), .FILT_LEN(FL), .BLANK_SHIFT(BS)) dut (
        .clk(clk), .rst(rst), .vr_in(vr_in), .blank_en(blank_en),
        .cap(cap), .cap_rise(cap_rise), .rejected(rejected),
        .period(period), .period_valid(period_valid), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: works on raw samples and time since the last accepted rise.
    logic         samp[$];
    logic         m_f = 1'b0, m_run = 1'b0;
    int           m_age = 0, m_win = 0;
    logic         m_cap = 1'b0, m_rise = 1'b0, m_rej = 1'b0, m_pv = 1'b0, m_ovf = 1'b0;
    logic [W-1:0] m_period = '0;

    task automatic m_reset();
        samp.delete();
        m_f = 0; m_run = 0; m_age = 0; m_win = 0;
        m_cap = 0; m_rise = 0; m_rej = 0; m_pv = 0; m_ovf = 0; m_period = '0;
    endtask

    task automatic m_step(input logic v, input logic ben);
        logic flip, acc;
        int   idx;
        samp.push_back(v);
        if (samp.size() > FL + 2) void'(samp.pop_front());
        // the filter sees a sample two clocks late; it needs FL in a row opposite to f
        flip = 1'b1;
        for (int i = 0; i < FL; i++) begin
            idx = samp.size() - 3 - i;
            if (((idx >= 0) ? samp[idx] : 1'b0) == m_f) flip = 1'b0;
        end
        m_rise = 0; m_rej = 0; m_pv = 0; acc = 0;
        if (m_age < 100000) m_age++;
        if (flip) begin
            m_f = !m_f;
            if (m_f) begin
                if (!m_run) begin
                    acc = 1; m_win = 0; m_ovf = 0; m_run = 1;
                end else if (!ben || m_age > m_win) begin
                    acc = 1; m_period = W'(m_age); m_pv = 1;
                    m_win = ben ? (m_age >> BS) : 0;
                end else begin
                    m_rej = 1;
                end
                if (acc) begin
                    m_cap = 1; m_rise = 1; m_age = 0;
                end
            end else begin
                m_cap = 0;
            end
        end
        if (m_run && !acc && m_age == (1 << W) - 1) begin
            m_ovf = 1; m_run = 0;
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) m_reset();
        else      m_step(vr_in, blank_en);
    end

    always @(negedge clk) begin
        check("cap", cap, m_cap);
        check("cap_rise", cap_rise, m_rise);
        check("rejected", rejected, m_rej);
        check("period", period, m_period);
        check("period_valid", period_valid, m_pv);
        check("ovf", ovf, m_ovf);
        cnt_rise += int'(cap_rise);
        cnt_pv   += int'(period_valid);
        cnt_rej  += int'(rejected);
        cnt_hi   += int'(cap);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tooth(input int hi, input int lo);
        vr_in = 1'b1;
        repeat (hi) step();
        vr_in = 1'b0;
        repeat (lo) step();
    endtask

    task automatic snap();
        b_rise = cnt_rise; b_pv = cnt_pv; b_rej = cnt_rej; b_hi = cnt_hi;
    endtask

    initial begin
        #2 rst = 1'b0;
        // reset held with a toggling input
        repeat (6) begin
            vr_in = ~vr_in;
            step();
        end
        check("rst_cap", cap, 0);
        check("rst_period", period, 0);
        check("rst_ovf", ovf, 0);
        vr_in = 1'b0;
        rst   = 1'b1;
        repeat (3) step();
        check("post_rst_cap", cap, 0);

        // 3-clock glitch never reaches cap
        snap();
        tooth(3, 10);
        check("glitch_cap", cap, 0);
        check("glitch_rise_cnt", cnt_rise - b_rise, 0);

        // steady high: cap follows five edges after the first sampling edge
        vr_in = 1'b1;
        repeat (5) step();
        check("edge_k4_cap", cap, 0);
        step();
        check("edge_k5_cap", cap, 1);
        check("edge_k5_rise", cap_rise, 1);
        check("first_no_pv", period_valid, 0);
        repeat (58) step();
        vr_in = 1'b0;
        repeat (64) step();

        // 128-clock square wave
        tooth(64, 64);
        check("sq_period", period, 128);
        snap();
        repeat (3) tooth(64, 64);
        check("sq_cap_hi", cnt_hi - b_hi, 192);
        check("sq_pv_cnt", cnt_pv - b_pv, 3);
        check("sq_period3", period, 128);

        // blanking: pulse at 20 is blanked, pulse at 40 accepted
        snap();
        tooth(8, 12);
        tooth(8, 100);
        check("blank20_rej", cnt_rej - b_rej, 1);
        check("blank20_period", period, 128);
        tooth(8, 32);
        tooth(8, 92);
        check("blank40_period", period, 40);
        check("blank40_rej", cnt_rej - b_rej, 1);

        // blanking disabled: pulse at 20 accepted
        vr_in = 1'b1;
        repeat (8) step();
        check("r2_period", period, 100);
        blank_en = 1'b0;
        vr_in = 1'b0;
        repeat (12) step();
        tooth(8, 120);
        check("noblank20_period", period, 20);
        check("noblank20_rej", cnt_rej - b_rej, 1);

        // window edge: 32 clocks is still blanked, 33 is accepted
        blank_en = 1'b1;
        tooth(8, 24);
        tooth(8, 88);
        check("edge32_rej", cnt_rej - b_rej, 2);
        check("edge32_period", period, 128);
        tooth(8, 25);
        vr_in = 1'b1;
        repeat (8) step();
        check("edge33_period", period, 33);

        // overflow after the input stops
        vr_in = 1'b0;
        repeat (300) step();
        check("ovf_set", ovf, 1);
        check("ovf_period_hold", period, 33);
        snap();
        tooth(10, 90);
        check("ovf_rise_cnt", cnt_rise - b_rise, 1);
        check("ovf_no_pv", cnt_pv - b_pv, 0);
        check("ovf_clear", ovf, 0);
        vr_in = 1'b1;
        repeat (10) step();
        check("ovf_next_period", period, 100);
        check("ovf_next_pv", cnt_pv - b_pv, 1);
        vr_in = 1'b0;
        repeat (20) step();

        // reset during a blanking window
        vr_in = 1'b1;
        repeat (8) step();
        vr_in = 1'b0;
        repeat (8) step();
        rst = 1'b0;
        #1;
        check("midrst_cap", cap, 0);
        check("midrst_period", period, 0);
        check("midrst_pv", period_valid, 0);
        check("midrst_ovf", ovf, 0);
        repeat (3) step();
        rst = 1'b1;
        repeat (5) step();
        snap();
        tooth(10, 40);
        check("midrst_first_rise", cnt_rise - b_rise, 1);
        check("midrst_first_no_pv", cnt_pv - b_pv, 0);
        tooth(10, 40);
        check("midrst_period50", period, 50);
        check("midrst_pv_cnt", cnt_pv - b_pv, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
